// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the instruction fetch front end.
//   fetch_state_t : controller state encoding (FETCH / WAIT / DRAIN)
//   PC_INCR       : byte distance between consecutive instruction words
//   fetch_entry_t : one buffered instruction, {pc, instr}
// ---------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INCR = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Two-entry in-order buffer of fetched {pc, instr} pairs.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (empties the buffer)
//   push        : write push_entry at the tail (caller guarantees count < 2)
//   pop         : drop the head entry (caller guarantees count > 0)
//   flush       : empty the buffer; overrides push and pop
//   push_entry  : entry written on push
//   count       : current occupancy, 0..2
//   head        : oldest entry; meaningless when count == 0
// ---------------------------------------------------------------------------
module fetch_buffer
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entries [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // Pointers toggle between the two slots; a simultaneous push and pop
  // moves both pointers and leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
// Instruction fetch unit: issues one word read at a time, buffers up to two
// returned instructions for decode, handles redirects and flags memory
// response timeouts.
// Parameters:
//   RESET_PC : fetch address loaded on reset
//   TIMEOUT  : cycles allowed in WAIT/DRAIN before fetch_error is raised
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   stall           : decode is holding; the presented instruction is kept
//   redirect_valid  : taken branch/jump this cycle
//   redirect_pc     : new fetch byte address (low two bits ignored)
//   mem_req         : single-cycle read request
//   mem_addr        : word-aligned byte address of the request
//   mem_rvalid      : read data valid
//   mem_rdata       : returned instruction word
//   inst_valid      : inst/inst_pc carry a fetched instruction
//   inst, inst_pc   : buffer head word and its byte address
//   fetch_error     : sticky response-timeout flag
// ---------------------------------------------------------------------------
module fetch_controller
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_error
);

  localparam int                  TIMER_W      = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]  TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);

  fetch_state_t       state;
  logic [31:0]        fetch_pc;
  logic [TIMER_W-1:0] timeout_cnt;
  logic [31:0]        redirect_target;
  logic               issue;
  logic               push;
  logic               pop;
  logic [1:0]         occupancy;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;
  logic               unused_redirect_bits;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // A request is only issued while the buffer has room for its response,
  // so a returning word can always be pushed.
  assign issue      = (state == FETCH) && (occupancy < 2'd2) && !redirect_valid;
  assign mem_req    = issue && !reset;
  assign mem_addr   = fetch_pc;

  // A redirect hides the buffer in the same cycle so decode never sees a
  // wrong-path instruction, and no pop is taken.
  assign inst_valid = (occupancy != 2'd0) && !redirect_valid && !reset;
  assign pop        = inst_valid && !stall;
  assign push       = (state == WAIT) && mem_rvalid && !redirect_valid;
  assign push_entry = '{pc: fetch_pc, instr: mem_rdata};
  assign inst       = head.instr;
  assign inst_pc    = head.pc;

  fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .count      (occupancy),
    .head       (head)
  );

  // Main fetch FSM plus the response timer. The timer is held at zero in
  // FETCH so it restarts on every entry to WAIT, and again on WAIT->DRAIN.
  // Once the error is raised the timer freezes so it cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      timeout_cnt <= '0;
      fetch_error <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          timeout_cnt <= '0;
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
          end else if (issue) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            fetch_pc    <= redirect_target;
            timeout_cnt <= '0;
            state       <= mem_rvalid ? FETCH : DRAIN;
          end else if (mem_rvalid) begin
            fetch_pc <= fetch_pc + PC_INCR;
            state    <= FETCH;
          end else if (!fetch_error) begin
            timeout_cnt <= timeout_cnt + TIMER_W'(1);
            if (timeout_cnt == TIMEOUT_LAST) begin
              fetch_error <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // The response to the abandoned request ends the drain even if
          // another redirect lands in the same cycle: nothing is left in
          // flight afterwards.
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
          end
          if (mem_rvalid) begin
            state <= FETCH;
          end else if (!fetch_error) begin
            timeout_cnt <= timeout_cnt + TIMER_W'(1);
            if (timeout_cnt == TIMEOUT_LAST) begin
              fetch_error <= 1'b1;
            end
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
// Directed bench for fetch_controller. Requests and consumed instructions are
// checked by a negedge monitor against queues filled by the stimulus; the
// stimulus additionally checks per-cycle handshake timing and the error flag.
// Memory model: fixed 2-cycle latency, data = 32'hC0DE_0000 | addr[15:0].
// ---------------------------------------------------------------------------
module tb_fetch_controller;

  localparam int MEM_LAT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_inst_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_error;

  int          check_count = 0;
  int          error_count = 0;
  logic [31:0] addr_q [$];
  exp_inst_t   inst_q [$];
  bit          mem_respond = 1'b1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_wait = 0;

  fetch_controller #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_error    (fetch_error)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Instruction memory: answers each request MEM_LAT cycles later unless
  // mem_respond is cleared; in-flight state is dropped while reset is high.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend_wait = pend_wait - 1;
        if (pend_wait == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= 32'hC0DE_0000 | {16'h0, pend_addr[15:0]};
          pend = 1'b0;
        end
      end
      if (mem_req && mem_respond) begin
        pend      = 1'b1;
        pend_addr = mem_addr;
        pend_wait = MEM_LAT - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every request and every consumed instruction must
  // match the next expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req) begin
        if (addr_q.size() == 0) begin
          check_count++;
          error_count++;
          $display("[TB] FAIL unexpected_req: got addr %h, expected no request", mem_addr);
        end else begin
          checkOutput("mem_addr", mem_addr, addr_q.pop_front());
        end
      end
      if (inst_valid && !stall) begin
        if (inst_q.size() == 0) begin
          check_count++;
          error_count++;
          $display("[TB] FAIL unexpected_inst: got pc %h inst %h, expected none", inst_pc, inst);
        end else begin
          exp_inst_t e;
          e = inst_q.pop_front();
          checkOutput("inst_pc", inst_pc, e.pc);
          checkOutput("inst", inst, e.inst);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic stl, input logic rv,
                               input logic [31:0] rpc);
    reset          = rst;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectAddr(input logic [31:0] a);
    addr_q.push_back(a);
  endtask

  task automatic expectInst(input logic [31:0] pc, input logic [31:0] word);
    inst_q.push_back('{pc: pc, inst: word});
  endtask

  // Two reset cycles; outputs must be quiet throughout and the error flag
  // cleared once the first reset edge has passed.
  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checkFlag("reset_mem_req", mem_req, 1'b0);
      checkFlag("reset_inst_valid", inst_valid, 1'b0);
      if (r == 1) checkFlag("reset_fetch_error", fetch_error, 1'b0);
      nextCycle();
    end
  endtask

  task automatic checkQueuesEmpty(input string tag);
    checkOutput({tag, "_addr_left"}, 32'(addr_q.size()), 32'd0);
    checkOutput({tag, "_inst_left"}, 32'(inst_q.size()), 32'd0);
    addr_q.delete();
    inst_q.delete();
  endtask

  initial begin
    // Streaming fetch: one instruction every three cycles.
    $display("[TB] streaming fetch");
    doReset();
    expectAddr(32'h0); expectAddr(32'h4); expectAddr(32'h8); expectAddr(32'hC);
    expectInst(32'h0, 32'hC0DE_0000);
    expectInst(32'h4, 32'hC0DE_0004);
    expectInst(32'h8, 32'hC0DE_0008);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkFlag("t1_mem_req", mem_req, (c % 3 == 1));
      checkFlag("t1_inst_valid", inst_valid, (c % 3 == 1) && (c > 1));
      nextCycle();
    end
    checkQueuesEmpty("t1");

    // Stall for ten cycles: buffer fills to two, requests stop.
    $display("[TB] stall saturation");
    doReset();
    expectAddr(32'h0); expectAddr(32'h4); expectAddr(32'h8);
    expectInst(32'h0, 32'hC0DE_0000);
    expectInst(32'h4, 32'hC0DE_0004);
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1'b0, (c <= 10), 1'b0, 32'h0);
      @(negedge clk);
      checkFlag("t2_mem_req", mem_req, (c == 1) || (c == 4) || (c == 12));
      checkFlag("t2_inst_valid", inst_valid, (c >= 4));
      if (c == 10) checkOutput("t2_head_pc", inst_pc, 32'h0);
      nextCycle();
    end
    checkQueuesEmpty("t2");

    // Redirect while waiting: response for pc 4 is dropped.
    $display("[TB] redirect in WAIT");
    doReset();
    expectAddr(32'h0); expectAddr(32'h4); expectAddr(32'h40); expectAddr(32'h44);
    expectInst(32'h0, 32'hC0DE_0000);
    expectInst(32'h40, 32'hC0DE_0040);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b0, 1'b0, (c == 5), 32'h40);
      @(negedge clk);
      checkFlag("t3_mem_req", mem_req, (c == 1) || (c == 4) || (c == 7) || (c == 10));
      checkFlag("t3_inst_valid", inst_valid, (c == 4) || (c == 10));
      nextCycle();
    end
    checkQueuesEmpty("t3");

    // Redirect to an unaligned target in the same cycle as the response.
    $display("[TB] redirect with response");
    doReset();
    expectAddr(32'h0); expectAddr(32'h4); expectAddr(32'h40); expectAddr(32'h44);
    expectInst(32'h40, 32'hC0DE_0040);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b0, (c <= 6), (c == 6), 32'h43);
      @(negedge clk);
      checkFlag("t4_mem_req", mem_req, (c == 1) || (c == 4) || (c == 7) || (c == 10));
      checkFlag("t4_inst_valid", inst_valid, (c == 4) || (c == 5) || (c == 10));
      if (c == 6) checkFlag("t4_rvalid_seen", mem_rvalid, 1'b1);
      nextCycle();
    end
    checkQueuesEmpty("t4");

    // Memory never answers: error exactly 16 cycles after entering WAIT.
    $display("[TB] response timeout");
    doReset();
    mem_respond = 1'b0;
    expectAddr(32'h0);
    for (int c = 1; c <= 30; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkFlag("t5_mem_req", mem_req, (c == 1));
      checkFlag("t5_fetch_error", fetch_error, (c >= 18));
      nextCycle();
    end
    checkQueuesEmpty("t5a");
    doReset();
    mem_respond = 1'b1;
    expectAddr(32'h0); expectAddr(32'h4);
    expectInst(32'h0, 32'hC0DE_0000);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkFlag("t5_after_mem_req", mem_req, (c == 1) || (c == 4));
      checkFlag("t5_after_error", fetch_error, 1'b0);
      nextCycle();
    end
    checkQueuesEmpty("t5b");

    // Address wrap from the top of the address space.
    $display("[TB] pc wrap");
    doReset();
    expectAddr(32'hFFFF_FFFC); expectAddr(32'h0000_0000);
    expectInst(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b0, 1'b0, (c == 1), 32'hFFFF_FFFE);
      @(negedge clk);
      checkFlag("t6_mem_req", mem_req, (c == 2) || (c == 5));
      checkFlag("t6_inst_valid", inst_valid, (c == 5));
      nextCycle();
    end
    checkQueuesEmpty("t6");

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for mem_rvalid before flagging an error.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1: decode stage holding; the instruction output is not consumed this cycle.
REQ-006 SHALL have port redirect_valid  input  1: branch or jump taken this cycle.
REQ-007 SHALL have port redirect_pc  input  32: new fetch byte address; bits [1:0] are ignored and treated as 0.
REQ-008 SHALL have port mem_req  output  1: single-cycle read request to instruction memory.
REQ-009 SHALL have port mem_addr  output  32: byte address of the request, word-aligned; memory indexes by mem_addr>>2.
REQ-010 SHALL have port mem_rvalid  input  1: read data is valid this cycle.
REQ-011 SHALL have port mem_rdata  input  32: instruction word returned by memory.
REQ-012 SHALL have port inst_valid  output  1: inst and inst_pc hold a fetched instruction.
REQ-013 SHALL have port inst  output  32: instruction word at the buffer head.
REQ-014 SHALL have port inst_pc  output  32: byte address of inst.
REQ-015 SHALL have port fetch_error  output  1: sticky flag for a memory response timeout.

Function
REQ-016 SHALL keep a 2-entry in-order buffer of {pc, instr} pairs and a fetch_pc register.
REQ-017 SHALL allow at most one memory request outstanding at any time.
REQ-018 SHALL implement three states:
- FETCH: issue a request.
- WAIT: request outstanding.
- DRAIN: outstanding response is to be discarded.
REQ-019 FETCH: when buffer occupancy < 2 and redirect_valid=0, SHALL assert mem_req with mem_addr=fetch_pc and go to WAIT; otherwise stay in FETCH with mem_req=0.
REQ-020 WAIT: on mem_rvalid, SHALL write {fetch_pc, mem_rdata} to the buffer tail, set fetch_pc=fetch_pc+4 (mod 2^32) and go to FETCH.
REQ-021 The earliest next request after a response SHALL be issued in the cycle after mem_rvalid, giving a throughput of one instruction per (memory latency + 1) cycles.
REQ-022 inst_valid SHALL be 1 whenever the buffer is non-empty and redirect_valid=0.
REQ-023 inst and inst_pc SHALL show the buffer head; they are don't-care when inst_valid=0.
REQ-024 An entry SHALL be popped in a cycle where inst_valid=1 and stall=0.
REQ-025 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-026 On redirect_valid=1, SHALL flush the buffer and set fetch_pc={redirect_pc[31:2],2'b00}; no pop is counted that cycle.
REQ-027 Redirect in FETCH SHALL move to FETCH with no request that cycle.
REQ-028 Redirect in WAIT, with or without mem_rvalid in the same cycle:
- without mem_rvalid: SHALL go to DRAIN;
- with mem_rvalid: SHALL discard the data and go to FETCH.
REQ-029 DRAIN: SHALL discard the data on mem_rvalid and go to FETCH.
REQ-030 A redirect during DRAIN SHALL update fetch_pc and keep the state in DRAIN.
REQ-031 mem_rvalid in FETCH SHALL be ignored.
REQ-032 SHALL count the cycles spent in WAIT or DRAIN, reset the count on entry to either state, and set fetch_error=1 when it reaches TIMEOUT.
REQ-033 fetch_error SHALL remain set until reset; fetching continues while waiting.

Reset
REQ-034 On reset=1 at a clock edge, SHALL set:
- state=FETCH, fetch_pc=RESET_PC;
- buffer empty, timeout count=0, fetch_error=0.
REQ-035 During and at the edge of reset, SHALL drive mem_req=0 and inst_valid=0.
REQ-036 A response arriving after reset from a request made before reset SHALL be ignored, since the state is FETCH.
REQ-037 The first request SHALL be issued in the first cycle with reset=0, with mem_addr=RESET_PC.

Structure
REQ-038 SHALL place the state encoding (FETCH, WAIT, DRAIN) and the PC increment constant (4) in the shared package pipeline_pkg.
REQ-039 The 2-entry buffer SHALL be a sub-module fetch_buffer, which provides push, pop, flush, a count output and a head output.

Verification
REQ-040 Reset, then memory with 2-cycle latency and stall=0 -> mem_addr=0,4,8,12 in sequence; inst_pc=0,4,8 with the matching mem_rdata; one instruction every 3 cycles.
REQ-041 Hold stall=1 for 10 cycles -> occupancy saturates at 2, mem_req stays 0; after release the entries are popped in order with pc=0 then 4.
REQ-042 redirect_valid=1 with redirect_pc=32'h40 while in WAIT -> state DRAIN, the pending response is discarded, the next mem_addr=32'h40, and no instruction with inst_pc=4 appears.
REQ-043 redirect_pc=32'h43 together with mem_rvalid in WAIT -> the data is dropped, the next mem_addr=32'h40, and inst_valid=0 in the redirect cycle.
REQ-044 Memory never responds -> fetch_error=1 exactly 16 cycles after entering WAIT and stays 1; reset clears it and the next request has mem_addr=0.
REQ-045 fetch_pc=32'hFFFF_FFFC -> the next mem_addr wraps to 32'h0000_0000.
